multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control unit for the 32-bit multicycle MIPS core.
- Moore state machine that sequences the shared-ALU datapath through fetch, decode, execute, memory and write-back steps.
- Consumes the opcode from the instruction register and drives every datapath control strobe, plus the memory read/write strobes and the ALUOp code for the ALU controller.
- Supports R-type, lw, sw, beq, j and addi.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_J, 6'h02, jump opcode
OP_ADDI, 6'h08, add-immediate opcode

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  opcode from instruction register (instruction[31:26])
PCWriteCond  output  1  PC write qualified by ALU zero (branch)
PCWrite  output  1  unconditional PC write
PCSource  output  2  next-PC select: 0 ALU result, 1 ALU-out register, 2 jump target
IorD  output  1  memory address select: 0 PC, 1 ALU-out register
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemToReg  output  1  register write data: 0 ALU-out, 1 memory data register
IRWrite  output  1  instruction register load
RegWrite  output  1  register file write
RegDst  output  1  destination register: 0 rt, 1 rd
ALUSrcA  output  1  ALU A: 0 PC, 1 register A
ALUSrcB  output  2  ALU B: 0 register B, 1 const 4, 2 sign-extended imm, 3 sign-extended imm<<2
ALUOp  output  2  0 add, 1 subtract, 2 decode funct
state  output  4  current state code (debug)
instrRetired  output  1  one-cycle pulse in the final state of each instruction
illegalOp  output  1  trap indicator (see Optional Feature)

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, IDLE=14, TRAP=15. All other codes go to IDLE.
- Reset: asynchronously forces IDLE. All outputs are 0 in IDLE. IDLE goes to FETCH on the first clock after reset deasserts. Reset mid-instruction aborts it immediately with no further strobes.
- All outputs decode purely from the state register (Moore, no combinational path from op). Outputs not listed for a state are 0.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=1, ALUOp=0, PCSource=0, IorD=0, ALUSrcA=0.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into the ALU-out register).
  - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0.
  - MEMRD: MemRead, IorD=1.
  - MEMWB: RegWrite, RegDst=0, MemToReg=1.
  - MEMWR: MemWrite, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2.
  - ALUWB: RegWrite, RegDst=1, MemToReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond, PCSource=1.
  - JUMP: PCWrite, PCSource=2.
  - ADDIWB: RegWrite, RegDst=0, MemToReg=0.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE samples op (op is valid because IR loaded at the end of FETCH):
    - lw/sw go to MEMADR.
    - R-type goes to EXEC.
    - beq goes to BRANCH.
    - j goes to JUMP.
    - addi goes to ADDIEX.
    - Other opcodes: see Optional Feature.
  - MEMADR goes to MEMRD for lw and to MEMWR for sw. op is re-read here; IR is stable because IRWrite is 0 outside FETCH.
  - MEMRD goes to MEMWB.
  - EXEC goes to ALUWB.
  - ADDIEX goes to ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, JUMP and ADDIWB go to FETCH.
- instrRetired is 1 in MEMWB, MEMWR, ALUWB, BRANCH, JUMP and ADDIWB, and only there.
- Cycle counts from FETCH to the retire state, inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Invariants:
  - IRWrite, PCWrite and RegWrite are never asserted together.
  - MemRead and MemWrite are never both 1.
  - PCWrite and PCWriteCond are never both 1.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unrecognised op in DECODE goes to TRAP. TRAP holds illegalOp=1 with all other strobes 0 and no retire pulse. TRAP is left only by reset.
- Undefined: an unrecognised op in DECODE goes to FETCH (2-cycle NOP, no instrRetired pulse). TRAP is unreachable and illegalOp is tied 0.

Test Plan:
- Reset: assert reset mid-EXEC -> same instant state=14, all strobes 0. Release -> state=0 next edge, MemRead=IRWrite=PCWrite=1.
- lw (op=6'h23) -> state sequence 0,1,2,3,4. MEMRD has MemRead=1, IorD=1. MEMWB has RegWrite=1, MemToReg=1, RegDst=0. instrRetired pulses once.
- sw (op=6'h2B) -> 0,1,2,5. MemWrite=1 only in state 5, RegWrite never 1. R-type (op=0) -> 0,1,6,7 with ALUOp=2 in EXEC and RegDst=1 in ALUWB.
- beq (op=6'h04) -> 0,1,8: PCWriteCond=1, PCSource=1, ALUOp=1. j (op=6'h02) -> 0,1,9: PCWrite=1, PCSource=2. addi (op=6'h08) -> 0,1,10,11 with ALUSrcB=2 then RegWrite=1, RegDst=0.
- op=6'h3F: with ILLEGAL_OP_TRAP_EN -> state 15, illegalOp=1 held for 20 cycles until reset. Without it -> 0,1,0, no instrRetired pulse.
- Random back-to-back mix of 200 instructions -> invariants hold every cycle. instrRetired count equals the number of legal instructions issued.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`timescale 1ns/1ps
// multicycle_control_fsm
// ----------------------
// Main control unit for the 32-bit multicycle MIPS core. This is a Moore state
// machine that steps the shared-ALU datapath through the fetch, decode,
// execute, memory and write-back steps. It supports R-type, lw, sw, beq, j and
// addi. Every output is a register that is loaded from the next state, so each
// output is a pure function of the state register. There is no combinational
// path from op to any output.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high reset; forces IDLE, all outputs 0
//   op           : opcode from the instruction register (instruction[31:26])
//   PCWriteCond  : PC write qualified by ALU zero (branch)
//   PCWrite      : unconditional PC write
//   PCSource     : next-PC select (0 ALU result, 1 ALU-out reg, 2 jump target)
//   IorD         : memory address select (0 PC, 1 ALU-out reg)
//   MemRead      : memory read strobe
//   MemWrite     : memory write strobe
//   MemToReg     : register write data (0 ALU-out, 1 memory data reg)
//   IRWrite      : instruction register load
//   RegWrite     : register file write
//   RegDst       : destination register (0 rt, 1 rd)
//   ALUSrcA      : ALU A (0 PC, 1 register A)
//   ALUSrcB      : ALU B (0 reg B, 1 const 4, 2 sext imm, 3 sext imm<<2)
//   ALUOp        : 0 add, 1 subtract, 2 decode funct
//   state        : current state code (debug)
//   instrRetired : one-cycle pulse in the final state of each instruction
//   illegalOp    : trap indicator
//
// Optional feature, macro ILLEGAL_OP_TRAP_EN:
//   defined   - an unrecognised op in DECODE enters TRAP. TRAP holds illegalOp
//               high until reset.
//   undefined - an unrecognised op in DECODE returns to FETCH as a 2-cycle NOP.
//               illegalOp is tied low.

module multicycle_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_J     = 6'h02,
   parameter logic [5:0] OP_ADDI  = 6'h08
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   output logic       PCWriteCond,
   output logic       PCWrite,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemToReg,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] state,
   output logic       instrRetired,
   output logic       illegalOp
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      IDLE   = 4'd14,
      TRAP   = 4'd15
   } state_t;

   state_t cur;
   state_t nxt;

   // Next-state rule. op is only looked at in DECODE and MEMADR. The
   // instruction register is loaded only in FETCH, so op stays stable for the
   // rest of the instruction.
   function automatic state_t next_of(input state_t s, input logic [5:0] o);
      next_of = IDLE;
      case (s)
         IDLE:   next_of = FETCH;
         FETCH:  next_of = DECODE;
         DECODE: begin
            case (o)
               OP_LW, OP_SW: next_of = MEMADR;
               OP_RTYPE:     next_of = EXEC;
               OP_BEQ:       next_of = BRANCH;
               OP_J:         next_of = JUMP;
               OP_ADDI:      next_of = ADDIEX;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      next_of = TRAP;
`else
               default:      next_of = FETCH;
`endif
            endcase
         end
         MEMADR: next_of = (o == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  next_of = MEMWB;
         EXEC:   next_of = ALUWB;
         ADDIEX: next_of = ADDIWB;
         MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB: next_of = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
         TRAP:   next_of = TRAP;
`endif
         default: next_of = IDLE;
      endcase
   endfunction

   always_comb nxt = next_of(cur, op);

   // The outputs are loaded from the decode of the next state. This keeps them
   // registered while still matching the state register cycle for cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur          <= IDLE;
         PCWriteCond  <= 1'b0;
         PCWrite      <= 1'b0;
         PCSource     <= 2'd0;
         IorD         <= 1'b0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
         MemToReg     <= 1'b0;
         IRWrite      <= 1'b0;
         RegWrite     <= 1'b0;
         RegDst       <= 1'b0;
         ALUSrcA      <= 1'b0;
         ALUSrcB      <= 2'd0;
         ALUOp        <= 2'd0;
         instrRetired <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
         illegalOp    <= 1'b0;
`endif
      end else begin
         cur          <= nxt;
         PCWriteCond  <= 1'b0;
         PCWrite      <= 1'b0;
         PCSource     <= 2'd0;
         IorD         <= 1'b0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
         MemToReg     <= 1'b0;
         IRWrite      <= 1'b0;
         RegWrite     <= 1'b0;
         RegDst       <= 1'b0;
         ALUSrcA      <= 1'b0;
         ALUSrcB      <= 2'd0;
         ALUOp        <= 2'd0;
         instrRetired <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
         illegalOp    <= (nxt == TRAP);
`endif
         case (nxt)
            FETCH: begin
               MemRead <= 1'b1;
               IRWrite <= 1'b1;
               PCWrite <= 1'b1;
               ALUSrcB <= 2'd1;
            end
            DECODE: begin
               // Branch target is precomputed into the ALU-out register.
               ALUSrcB <= 2'd3;
            end
            MEMADR, ADDIEX: begin
               ALUSrcA <= 1'b1;
               ALUSrcB <= 2'd2;
            end
            MEMRD: begin
               MemRead <= 1'b1;
               IorD    <= 1'b1;
            end
            MEMWB: begin
               RegWrite     <= 1'b1;
               MemToReg     <= 1'b1;
               instrRetired <= 1'b1;
            end
            MEMWR: begin
               MemWrite     <= 1'b1;
               IorD         <= 1'b1;
               instrRetired <= 1'b1;
            end
            EXEC: begin
               ALUSrcA <= 1'b1;
               ALUOp   <= 2'd2;
            end
            ALUWB: begin
               RegWrite     <= 1'b1;
               RegDst       <= 1'b1;
               instrRetired <= 1'b1;
            end
            BRANCH: begin
               ALUSrcA      <= 1'b1;
               ALUOp        <= 2'd1;
               PCWriteCond  <= 1'b1;
               PCSource     <= 2'd1;
               instrRetired <= 1'b1;
            end
            JUMP: begin
               PCWrite      <= 1'b1;
               PCSource     <= 2'd2;
               instrRetired <= 1'b1;
            end
            ADDIWB: begin
               RegWrite     <= 1'b1;
               instrRetired <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

`ifndef ILLEGAL_OP_TRAP_EN
   assign illegalOp = 1'b0;
`endif

   assign state = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
`timescale 1ns/1ps
// Self-checking bench for multicycle_control_fsm. For each instruction, a
// reference model builds the expected state sequence from the opcode. It also
// builds the expected control strobes for each step from the per-state table.
// Every cycle is compared against the DUT, including the safety invariants.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg;
   logic       IRWrite, RegWrite, RegDst, ALUSrcA, instrRetired, illegalOp;
   logic [1:0] PCSource, ALUSrcB, ALUOp;
   logic [3:0] state;

   int n_assert = 0;
   int n_fail   = 0;
   int ret_seen = 0;
   int legal_cnt = 0;
   int seq[$];

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .op(op),
      .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .PCSource(PCSource),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state),
      .instrRetired(instrRetired), .illegalOp(illegalOp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packed order: PCWriteCond PCWrite PCSource IorD MemRead MemWrite MemToReg
   //               IRWrite RegWrite RegDst ALUSrcA ALUSrcB ALUOp instrRetired illegalOp
   function automatic logic [17:0] obs_ctl();
      return {PCWriteCond, PCWrite, PCSource, IorD, MemRead, MemWrite, MemToReg,
              IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, instrRetired, illegalOp};
   endfunction

   // Expected strobes for each state code, taken from the control table.
   function automatic logic [17:0] exp_ctl(input int st);
      logic pwc, pw, iord, mr, mw, m2r, irw, rw, rd, asa, ret, ill;
      logic [1:0] ps, asb, aop;
      {pwc, pw, iord, mr, mw, m2r, irw, rw, rd, asa, ret, ill} = '0;
      ps = 2'd0; asb = 2'd0; aop = 2'd0;
      case (st)
         0:  begin mr = 1; irw = 1; pw = 1; asb = 2'd1; end
         1:  asb = 2'd3;
         2, 10: begin asa = 1; asb = 2'd2; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; ret = 1; end
         5:  begin mw = 1; iord = 1; ret = 1; end
         6:  begin asa = 1; aop = 2'd2; end
         7:  begin rw = 1; rd = 1; ret = 1; end
         8:  begin asa = 1; aop = 2'd1; pwc = 1; ps = 2'd1; ret = 1; end
         9:  begin pw = 1; ps = 2'd2; ret = 1; end
         11: begin rw = 1; ret = 1; end
         15: ill = 1;
         default: ;
      endcase
      return {pwc, pw, ps, iord, mr, mw, m2r, irw, rw, rd, asa, asb, aop, ret, ill};
   endfunction

   // Builds the expected state walk for one instruction and reports whether it is legal.
   task automatic build_seq(input logic [5:0] o, output bit legal);
      seq = {0, 1};
      legal = 1'b1;
      case (o)
         6'h23: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
         6'h2B: begin seq.push_back(2); seq.push_back(5); end
         6'h00: begin seq.push_back(6); seq.push_back(7); end
         6'h04: seq.push_back(8);
         6'h02: seq.push_back(9);
         6'h08: begin seq.push_back(10); seq.push_back(11); end
         default: begin
            legal = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            seq.push_back(15);
`endif
         end
      endcase
   endtask

   // Checks the current cycle (sampled 1 ns after the edge) and then advances one clock.
   task automatic step_check(input int exp_st, input string tag);
      chk({tag, " state"}, 32'(state), 32'(exp_st));
      chk({tag, " ctl"}, 32'(obs_ctl()), 32'(exp_ctl(exp_st)));
      chk({tag, " inv_irw_pw_rw"}, 32'(IRWrite & PCWrite & RegWrite), 32'd0);
      chk({tag, " inv_mr_mw"}, 32'(MemRead & MemWrite), 32'd0);
      chk({tag, " inv_pw_pwc"}, 32'(PCWrite & PCWriteCond), 32'd0);
      if (instrRetired === 1'b1) ret_seen++;
      @(posedge clk); #1;
   endtask

   task automatic run_instr(input logic [5:0] o, input string tag);
      bit legal;
      op = o;
      build_seq(o, legal);
      foreach (seq[k]) step_check(seq[k], $sformatf("%s s%0d", tag, k));
      if (legal) legal_cnt++;
   endtask

   // Asserts reset between clock edges, checks the immediate abort into IDLE,
   // and releases reset so that the next edge lands in FETCH.
   task automatic reset_pulse(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, " async state"}, 32'(state), 32'd14);
      chk({tag, " async ctl"}, 32'(obs_ctl()), 32'd0);
      @(posedge clk); #1;
      chk({tag, " held state"}, 32'(state), 32'd14);
      chk({tag, " held ctl"}, 32'(obs_ctl()), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [5:0] legal_ops [6];
      logic [5:0] o;
      legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};

      // Power-on reset
      reset = 1'b1;
      op = 6'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("por state", 32'(state), 32'd14);
      chk("por ctl", 32'(obs_ctl()), 32'd0);
      reset = 1'b0;
      #1;
      chk("release pre-edge state", 32'(state), 32'd14);
      @(posedge clk); #1;
      chk("release MemRead", 32'(MemRead), 32'd1);
      chk("release IRWrite", 32'(IRWrite), 32'd1);

      // Directed instructions, one of each
      run_instr(6'h23, "lw");
      run_instr(6'h2B, "sw");
      run_instr(6'h00, "rtype");
      run_instr(6'h04, "beq");
      run_instr(6'h02, "j");
      run_instr(6'h08, "addi");
      chk("retire count directed", 32'(ret_seen), 32'(legal_cnt));

      // Reset in the middle of EXEC aborts the instruction
      op = 6'h00;
      step_check(0, "abort s0");
      step_check(1, "abort s1");
      chk("abort in EXEC", 32'(state), 32'd6);
      reset_pulse("rst midexec");

      // Illegal opcode
`ifdef ILLEGAL_OP_TRAP_EN
      run_instr(6'h3F, "illegal");
      for (int i = 0; i < 19; i++) step_check(15, $sformatf("trap hold %0d", i));
      reset_pulse("rst trap");
`else
      run_instr(6'h3F, "illegal");
      run_instr(6'h08, "after illegal");
`endif
      chk("retire count after illegal", 32'(ret_seen), 32'(legal_cnt));

      // Random back-to-back mix of instructions
      for (int i = 0; i < 200; i++) begin
         int r;
         r = int'($urandom_range(0, 7));
         if (r < 6) begin
            o = legal_ops[r];
         end else begin
`ifdef ILLEGAL_OP_TRAP_EN
            o = legal_ops[r - 6];
`else
            o = 6'($urandom_range(0, 63));
            while (o inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08})
               o = 6'($urandom_range(0, 63));
`endif
         end
         run_instr(o, $sformatf("rnd%0d op%0h", i, o));
      end
      chk("retire count random", 32'(ret_seen), 32'(legal_cnt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
